dmem_resp: RTL and testbench

//   Data-memory responder: the RAM-side end of the MEM-stage load/store path.

---
 rtl/dmem_resp_if.sv | 27 ++
 rtl/dmem_resp.sv | 178 +++++++++++++++++
 tb/tb_dmem_resp.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/dmem_resp_if.sv
// Request/response bundle between the MEM stage and the data-memory responder.
// The master drives requests; the slave grants and answers.
interface dmem_resp_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_i;
  logic                  we_i;
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [DATA_WIDTH-1:0] wdata_i;
  logic [1:0]            size_i;
  logic                  unsigned_i;
  logic                  gnt_o;
  logic                  rvalid_o;
  logic [DATA_WIDTH-1:0] rdata_o;
  logic                  err_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i, size_i, unsigned_i,
    input  gnt_o, rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, size_i, unsigned_i,
    output gnt_o, rvalid_o, rdata_o, err_o
  );
endinterface

// File: rtl/dmem_resp.sv
// Data-memory responder: lane steering, byte enables, load extension,
// misalignment checks and programmable wait states behind a req/gnt port.
module dmem_resp #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 4096,
  parameter int WAIT_CYCLES = 0
) (
  input  logic          clk,
  input  logic          rstn,
  dmem_resp_if.slave    bus
);
  localparam int IW = $clog2(DEPTH);
  localparam logic [3:0] WAIT4 = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t          state;
  logic [3:0]      cnt;
  logic            c_we;
  logic [IW+1:0]   c_addr;
  logic [31:0]     c_wdata;
  logic [1:0]      c_size;
  logic            c_uns;

  logic            rvalid_q;
  logic [31:0]     rdata_q;
  logic            err_q;

  logic            accept;
  logic            go_resp;
  logic            a_we;
  logic [IW+1:0]   a_addr;
  logic [31:0]     a_wdata;
  logic [1:0]      a_size;
  logic            a_uns;
  logic [IW-1:0]   idx;
  logic [1:0]      off;
  logic            mis;
  logic [3:0]      be;
  logic [31:0]     wd;
  logic [31:0]     rword;
  logic [7:0]      bsel;
  logic [15:0]     hsel;
  logic [31:0]     ld;
  logic [31:0]     rdata_n;
  logic            unused_bits;

  assign unused_bits = ^bus.addr_i[ADDR_WIDTH-1:IW+2];

  assign bus.gnt_o    = (state == IDLE);
  assign bus.rvalid_o = rvalid_q;
  assign bus.rdata_o  = rdata_q;
  assign bus.err_o    = err_q;

  assign accept  = bus.req_i & bus.gnt_o;
  assign go_resp = ((state == IDLE) && accept && (WAIT4 == 4'd0))
                || ((state == BUSY) && (cnt == 4'd0));

  // The zero-wait path answers on the accept edge, so it reads live inputs.
  always_comb begin
    a_we    = c_we;
    a_addr  = c_addr;
    a_wdata = c_wdata;
    a_size  = c_size;
    a_uns   = c_uns;
    if (state == IDLE) begin
      a_we    = bus.we_i;
      a_addr  = bus.addr_i[IW+1:0];
      a_wdata = bus.wdata_i;
      a_size  = bus.size_i;
      a_uns   = bus.unsigned_i;
    end
  end

  assign idx = a_addr[IW+1:2];
  assign off = a_addr[1:0];

  always_comb begin
    mis = 1'b1;
    be  = 4'b0000;
    wd  = a_wdata;
    unique case (a_size)
      2'b00: begin
        mis = 1'b0;
        be  = 4'b0001 << off;
        wd  = {4{a_wdata[7:0]}};
      end
      2'b01: begin
        mis = off[0];
        be  = off[1] ? 4'b1100 : 4'b0011;
        wd  = {2{a_wdata[15:0]}};
      end
      2'b10: begin
        mis = |off;
        be  = 4'b1111;
      end
      default: mis = 1'b1;
    endcase
  end

  assign rword = mem[idx];
  assign bsel  = 8'(rword >> {off, 3'b000});
  assign hsel  = off[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    ld = rword;
    unique case (a_size)
      2'b00:   ld = {{24{~a_uns & bsel[7]}}, bsel};
      2'b01:   ld = {{16{~a_uns & hsel[15]}}, hsel};
      default: ld = rword;
    endcase
  end

  assign rdata_n = (a_we | mis) ? 32'h0 : ld;

  always_ff @(posedge clk) begin
    if (rstn) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      c_we     <= 1'b0;
      c_addr   <= '0;
      c_wdata  <= 32'h0;
      c_size   <= 2'b00;
      c_uns    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      rdata_q  <= 32'h0;
      err_q    <= 1'b0;
      if (go_resp) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rdata_n;
        err_q    <= mis;
      end
      unique case (state)
        IDLE: begin
          if (accept) begin
            c_we    <= bus.we_i;
            c_addr  <= bus.addr_i[IW+1:0];
            c_wdata <= bus.wdata_i;
            c_size  <= bus.size_i;
            c_uns   <= bus.unsigned_i;
            if (WAIT4 == 4'd0) begin
              state <= RESP;
            end else begin
              state <= BUSY;
              cnt   <= WAIT4 - 4'd1;
            end
          end
        end
        BUSY: begin
          if (cnt == 4'd0) state <= RESP;
          else cnt <= cnt - 4'd1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Array has no reset; a reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (go_resp && a_we && !mis && !rstn) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_dmem_resp.sv
// Directed scoreboard bench for dmem_resp: one zero-wait and
// one three-wait instance share a stimulus driver.
module tb_dmem_resp;
  typedef struct packed {
    logic [31:0] rd;
    logic        er;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst0;
  logic        rst3;
  logic        sel;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  size;
  logic        uns;

  logic        o_gnt;
  logic        o_rvalid;
  logic [31:0] o_rdata;
  logic        o_err;

  int total = 0;
  int bad   = 0;

  exp_t  exp_q[$];
  string tag_q[$];

  always #5 clk = ~clk;

  dmem_resp_if b0 ();
  dmem_resp_if b3 ();

  assign b0.req_i      = req & ~sel;
  assign b0.we_i       = we;
  assign b0.addr_i     = addr;
  assign b0.wdata_i    = wdata;
  assign b0.size_i     = size;
  assign b0.unsigned_i = uns;
  assign b3.req_i      = req & sel;
  assign b3.we_i       = we;
  assign b3.addr_i     = addr;
  assign b3.wdata_i    = wdata;
  assign b3.size_i     = size;
  assign b3.unsigned_i = uns;

  assign o_gnt    = sel ? b3.gnt_o    : b0.gnt_o;
  assign o_rvalid = sel ? b3.rvalid_o : b0.rvalid_o;
  assign o_rdata  = sel ? b3.rdata_o  : b0.rdata_o;
  assign o_err    = sel ? b3.err_o    : b0.err_o;

  dmem_resp #(.WAIT_CYCLES(0)) dut0 (
    .clk  (clk),
    .rstn (rst0),
    .bus  (b0.slave)
  );

  dmem_resp #(.WAIT_CYCLES(3)) dut3 (
    .clk  (clk),
    .rstn (rst3),
    .bus  (b3.slave)
  );

  task automatic chk(input string tag, input logic [33:0] obs,
                     input logic [33:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic txn(input string tag, input logic w,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [1:0] s, input logic u,
                     input logic [31:0] er, input logic ee);
    int   n;
    int   lat;
    bit   seen;
    exp_t e;
    exp_q.push_back('{er, ee});
    tag_q.push_back(tag);
    @(negedge clk);
    we = w; addr = a; wdata = d; size = s; uns = u; req = 1'b1;
    n = 0;
    while (!o_gnt && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_gnt"}, {33'h0, o_gnt}, 34'h1);
    @(posedge clk);
    #1;
    req = 1'b0;
    we = 1'($urandom); addr = $urandom; wdata = $urandom;
    size = 2'($urandom); uns = 1'($urandom);
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 30) begin
      @(negedge clk);
      lat++;
      if (o_rvalid) seen = 1'b1;
      else chk({tag, "_gnt_busy"}, {33'h0, o_gnt}, 34'h0);
    end
    chk({tag, "_lat"}, 34'(seen ? lat : 99), 34'(sel ? 4 : 1));
    e = exp_q.pop_front();
    void'(tag_q.pop_front());
    if (seen) begin
      chk({tag, "_rdata"}, {2'b0, o_rdata}, {2'b0, e.rd});
      chk({tag, "_err"}, {33'h0, o_err}, {33'h0, e.er});
    end
    @(negedge clk);
    chk({tag, "_after"}, {o_rvalid, o_err, o_rdata},
        {1'b0, 1'b0, 32'h0});
    chk({tag, "_regnt"}, {33'h0, o_gnt}, 34'h1);
  endtask

  initial begin
    bit hit;
    rst0 = 1'b1; rst3 = 1'b1; sel = 1'b0; req = 1'b0;
    we = 1'b0; addr = 32'h0; wdata = 32'h0; size = 2'b00; uns = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst0", {b0.gnt_o, b0.rvalid_o, b0.err_o, b0.rdata_o[30:0]},
        {1'b1, 1'b0, 1'b0, 31'h0});
    chk("rst3", {b3.gnt_o, b3.rvalid_o, b3.err_o, b3.rdata_o[30:0]},
        {1'b1, 1'b0, 1'b0, 31'h0});
    rst0 = 1'b0; rst3 = 1'b0;

    txn("sw10",   1, 32'h10, 32'h12345678, 2'b10, 0, 32'h0, 0);
    txn("lw10",   0, 32'h10, 32'h0, 2'b10, 0, 32'h12345678, 0);
    txn("lb13",   0, 32'h13, 32'h0, 2'b00, 0, 32'h00000012, 0);
    txn("lh12",   0, 32'h12, 32'h0, 2'b01, 0, 32'h00001234, 0);
    txn("lhu10",  0, 32'h10, 32'h0, 2'b01, 1, 32'h00005678, 0);
    txn("sb11",   1, 32'h11, 32'hAAAAAA80, 2'b00, 0, 32'h0, 0);
    txn("lb11",   0, 32'h11, 32'h0, 2'b00, 0, 32'hFFFFFF80, 0);
    txn("lbu11",  0, 32'h11, 32'h0, 2'b00, 1, 32'h00000080, 0);
    txn("lw10b",  0, 32'h10, 32'h0, 2'b10, 0, 32'h12348078, 0);
    txn("sh11",   1, 32'h11, 32'h0000BEEF, 2'b01, 0, 32'h0, 1);
    txn("lw10c",  0, 32'h10, 32'h0, 2'b10, 0, 32'h12348078, 0);
    txn("ill",    0, 32'h10, 32'h0, 2'b11, 0, 32'h0, 1);
    txn("lw12",   0, 32'h12, 32'h0, 2'b10, 0, 32'h0, 1);
    txn("sw14",   1, 32'h14, 32'h01020304, 2'b10, 0, 32'h0, 0);
    txn("sh16",   1, 32'h16, 32'h5555ABCD, 2'b01, 0, 32'h0, 0);
    txn("lh16",   0, 32'h16, 32'h0, 2'b01, 0, 32'hFFFFABCD, 0);
    txn("lhu16",  0, 32'h16, 32'h0, 2'b01, 1, 32'h0000ABCD, 0);
    txn("lw14",   0, 32'h14, 32'h0, 2'b10, 0, 32'hABCD0304, 0);
    txn("wrap",   0, 32'h4010, 32'h0, 2'b10, 0, 32'h12348078, 0);

    sel = 1'b1;
    txn("w3_sw20", 1, 32'h20, 32'h11111111, 2'b10, 0, 32'h0, 0);
    txn("w3_lw20", 0, 32'h20, 32'h0, 2'b10, 0, 32'h11111111, 0);
    txn("w3_lb21", 0, 32'h21, 32'h0, 2'b00, 0, 32'h00000011, 0);

    @(negedge clk);
    we = 1'b1; addr = 32'h20; wdata = 32'hDEADBEEF; size = 2'b10;
    uns = 1'b0; req = 1'b1;
    chk("abort_gnt", {33'h0, o_gnt}, 34'h1);
    @(posedge clk);
    #1;
    req = 1'b0;
    @(negedge clk);
    chk("abort_busy", {33'h0, o_gnt}, 34'h0);
    rst3 = 1'b1;
    @(negedge clk);
    rst3 = 1'b0;
    chk("abort_regnt", {o_gnt, o_rvalid, 32'h0}, {1'b1, 1'b0, 32'h0});
    hit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (o_rvalid) hit = 1'b1;
    end
    chk("abort_norv", {33'h0, hit}, 34'h0);
    txn("w3_lw20b", 0, 32'h20, 32'h0, 2'b10, 0, 32'h11111111, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
